// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-sequencer bundle: instruction-memory handshake, core-side instruction
// hand-off, next-PC selection inputs and misaligned-target fault reporting.
interface pc_fetch_sequencer_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [1:0]  next_pc_select;
    logic [31:0] immediate;
    logic [31:0] jalr_target;
    logic        misaligned_fault;
    logic [31:0] fault_addr;
    logic        fault_ack;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output inst_valid, inst, inst_pc,
        input  inst_ready, next_pc_select, immediate, jalr_target,
        output misaligned_fault, fault_addr,
        input  fault_ack
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  inst_valid, inst, inst_pc,
        output inst_ready, next_pc_select, immediate, jalr_target,
        input  misaligned_fault, fault_addr,
        output fault_ack
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Single-outstanding instruction fetch loop: FETCH -> WAIT -> HOLD, with a
// FAULT detour when the chosen next PC is not word aligned.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0040_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0000
) (
    input  logic                 clock,
    input  logic                 reset_n,
    pc_fetch_sequencer_if.master bus
);
    typedef enum logic [1:0] {FETCH, WAIT, HOLD, FAULT} state_t;

    state_t      r_state, w_next_state;
    logic        r_live;
    logic [31:0] r_pc, r_inst, r_inst_pc, r_fault_addr;
    logic [31:0] w_target;
    logic        w_target_ok;
    logic        w_req_valid, w_inst_valid, w_fault;
    logic        w_take_resp, w_retire, w_ack;

    always_comb begin
        case (bus.next_pc_select)
            2'b00:   w_target = r_pc + 32'd4;
            2'b01:   w_target = r_pc + bus.immediate;
            2'b10:   w_target = bus.jalr_target & 32'hFFFF_FFFE;
            default: w_target = TRAP_VECTOR;
        endcase
    end
    assign w_target_ok = (w_target[1:0] == 2'b00);

    always_comb begin
        w_next_state = r_state;
        w_req_valid  = 1'b0;
        w_inst_valid = 1'b0;
        w_fault      = 1'b0;
        w_take_resp  = 1'b0;
        w_retire     = 1'b0;
        w_ack        = 1'b0;
        unique case (r_state)
            FETCH: begin
                // r_live keeps the request low until the first edge after reset release
                w_req_valid = r_live;
                if (r_live && bus.imem_req_ready) w_next_state = WAIT;
            end
            WAIT: begin
                if (bus.imem_resp_valid) begin
                    w_take_resp  = 1'b1;
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                w_inst_valid = 1'b1;
                if (bus.inst_ready) begin
                    w_retire     = 1'b1;
                    w_next_state = w_target_ok ? FETCH : FAULT;
                end
            end
            FAULT: begin
                w_fault = 1'b1;
                if (bus.fault_ack) begin
                    w_ack        = 1'b1;
                    w_next_state = FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= FETCH;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_live  <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc         <= RESET_PC;
            r_inst       <= 32'd0;
            r_inst_pc    <= 32'd0;
            r_fault_addr <= 32'd0;
        end else begin
            if (w_take_resp) begin
                r_inst    <= bus.imem_resp_data;
                r_inst_pc <= r_pc;
            end
            if (w_retire) begin
                if (w_target_ok) r_pc <= w_target;
                else             r_fault_addr <= w_target;
            end
            if (w_ack) r_pc <= TRAP_VECTOR;
        end
    end

    assign bus.imem_req_valid   = w_req_valid;
    assign bus.imem_req_addr    = r_pc;
    assign bus.inst_valid       = w_inst_valid;
    assign bus.inst             = r_inst;
    assign bus.inst_pc          = r_inst_pc;
    assign bus.misaligned_fault = w_fault;
    assign bus.fault_addr       = r_fault_addr;
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: a transaction-level model checked every
// cycle, plus literal expectations at the interesting points of the scenario.
`timescale 1ns/1ps
module tb_pc_fetch_sequencer;
    localparam logic [31:0] RESET_PC    = 32'h0040_0000;
    localparam logic [31:0] TRAP_VECTOR = 32'h0000_0000;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    logic run_cmp  = 1'b1;

    pc_fetch_sequencer_if bus();

    pc_fetch_sequencer #(.RESET_PC(RESET_PC), .TRAP_VECTOR(TRAP_VECTOR)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h expected=%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: which phase of the single-outstanding loop we are in, as flags.
    logic        m_live, m_req, m_wait, m_hold, m_fault;
    logic [31:0] m_pc, m_inst, m_inst_pc, m_fault_addr, m_tgt;

    function automatic logic [31:0] model_target(input logic [1:0] sel, input logic [31:0] pc,
                                                 input logic [31:0] imm, input logic [31:0] jt);
        case (sel)
            2'b00:   return pc + 32'd4;
            2'b01:   return pc + imm;
            2'b10:   return {jt[31:1], 1'b0};
            default: return TRAP_VECTOR;
        endcase
    endfunction

    assign m_tgt = model_target(bus.next_pc_select, m_pc, bus.immediate, bus.jalr_target);

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_live <= 1'b0; m_req <= 1'b1; m_wait <= 1'b0; m_hold <= 1'b0; m_fault <= 1'b0;
            m_pc <= RESET_PC; m_inst <= 32'd0; m_inst_pc <= 32'd0; m_fault_addr <= 32'd0;
        end else begin
            m_live <= 1'b1;
            if (m_req && m_live && bus.imem_req_ready) begin
                m_req <= 1'b0; m_wait <= 1'b1;
            end else if (m_wait && bus.imem_resp_valid) begin
                m_inst <= bus.imem_resp_data; m_inst_pc <= m_pc;
                m_wait <= 1'b0; m_hold <= 1'b1;
            end else if (m_hold && bus.inst_ready) begin
                m_hold <= 1'b0;
                if (m_tgt[1:0] == 2'b00) begin m_pc <= m_tgt; m_req <= 1'b1; end
                else begin m_fault_addr <= m_tgt; m_fault <= 1'b1; end
            end else if (m_fault && bus.fault_ack) begin
                m_pc <= TRAP_VECTOR; m_fault <= 1'b0; m_req <= 1'b1;
            end
        end
    end

    always @(negedge clock) begin
        if (run_cmp) begin
            check("cmp_req_valid", bus.imem_req_valid, m_live && m_req);
            check("cmp_req_addr", bus.imem_req_addr, m_pc);
            check("cmp_inst_valid", bus.inst_valid, m_hold);
            check("cmp_inst", bus.inst, m_inst);
            check("cmp_inst_pc", bus.inst_pc, m_inst_pc);
            check("cmp_fault", bus.misaligned_fault, m_fault);
            check("cmp_fault_addr", bus.fault_addr, m_fault_addr);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_hold(input string name, input logic [31:0] pc);
        int n = 0;
        while (!bus.inst_valid && n < 20) begin step(); n++; end
        check({name, "_reached"}, bus.inst_valid, 1);
        check(name, bus.inst_pc, pc);
    endtask

    task automatic expect_fetch(input string name, input logic [31:0] addr);
        int n = 0;
        while (!bus.imem_req_valid && n < 20) begin step(); n++; end
        check({name, "_reached"}, bus.imem_req_valid, 1);
        check(name, bus.imem_req_addr, addr);
    endtask

    // Retire the held instruction; selection inputs are scrambled afterwards
    task automatic retire(input logic [1:0] sel, input logic [31:0] imm, input logic [31:0] jt);
        bus.next_pc_select = sel; bus.immediate = imm; bus.jalr_target = jt; bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0; bus.next_pc_select = 2'b01;
        bus.immediate = 32'hDEAD_BEE2; bus.jalr_target = 32'h1234_5677;
    endtask

    initial begin
        bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0; bus.imem_resp_data = 32'd0;
        bus.inst_ready = 1'b0; bus.next_pc_select = 2'b00; bus.immediate = 32'd0;
        bus.jalr_target = 32'd0; bus.fault_ack = 1'b0;
        repeat (2) step();
        check("rst_req_valid", bus.imem_req_valid, 0);
        check("rst_addr", bus.imem_req_addr, 32'h0040_0000);
        check("rst_inst_valid", bus.inst_valid, 0);
        check("rst_inst", bus.inst, 0);
        check("rst_inst_pc", bus.inst_pc, 0);
        check("rst_fault", bus.misaligned_fault, 0);
        check("rst_fault_addr", bus.fault_addr, 0);

        // zero-wait memory, core always ready
        bus.imem_req_ready = 1'b1; bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data = 32'h0000_0013; bus.inst_ready = 1'b1;
        reset_n = 1'b1;
        step();
        check("first_req_valid", bus.imem_req_valid, 1);
        check("first_addr", bus.imem_req_addr, 32'h0040_0000);
        step();
        check("wait_req_low", bus.imem_req_valid, 0);
        step();
        check("first_inst_valid", bus.inst_valid, 1);
        check("first_inst", bus.inst, 32'h0000_0013);
        check("first_inst_pc", bus.inst_pc, 32'h0040_0000);
        step();
        check("second_valid", bus.imem_req_valid, 1);
        check("second_addr", bus.imem_req_addr, 32'h0040_0004);
        bus.inst_ready = 1'b0;

        wait_hold("h404", 32'h0040_0004); retire(2'b00, 0, 0);
        wait_hold("h408", 32'h0040_0008); retire(2'b00, 0, 0);
        wait_hold("h40c", 32'h0040_000C); retire(2'b00, 0, 0);
        wait_hold("h410", 32'h0040_0010); retire(2'b01, 32'hFFFF_FFF0, 0);
        expect_fetch("branch_back", 32'h0040_0000);

        wait_hold("h400", 32'h0040_0000); retire(2'b10, 0, 32'h0040_0021);
        expect_fetch("jalr_bit0", 32'h0040_0020);
        check("jalr_bit0_nofault", bus.misaligned_fault, 0);

        wait_hold("h420", 32'h0040_0020);
        bus.imem_req_ready = 1'b0;
        retire(2'b10, 0, 32'h0040_0022);
        check("fault_flag", bus.misaligned_fault, 1);
        check("fault_addr", bus.fault_addr, 32'h0040_0022);
        check("fault_req_low", bus.imem_req_valid, 0);
        check("fault_inst_low", bus.inst_valid, 0);
        check("fault_pc_kept", bus.imem_req_addr, 32'h0040_0020);
        repeat (2) step();
        check("fault_waits_ack", bus.misaligned_fault, 1);
        bus.fault_ack = 1'b1; step(); bus.fault_ack = 1'b0;

        for (int i = 0; i < 5; i++) begin
            check("stall_valid", bus.imem_req_valid, 1);
            check("stall_addr", bus.imem_req_addr, 32'h0000_0000);
            step();
        end
        bus.imem_req_ready = 1'b1;
        bus.imem_resp_data = 32'hCAFE_0001;
        wait_hold("h0", 32'h0000_0000);
        for (int i = 0; i < 4; i++) begin
            bus.imem_resp_data = 32'h5555_0000 + i;
            check("hold_inst", bus.inst, 32'hCAFE_0001);
            check("hold_inst_pc", bus.inst_pc, 32'h0000_0000);
            step();
        end

        retire(2'b01, 32'hFFFF_FFFC, 0);
        expect_fetch("to_top", 32'hFFFF_FFFC);
        wait_hold("htop", 32'hFFFF_FFFC); retire(2'b00, 0, 0);
        expect_fetch("wrap", 32'h0000_0000);
        check("wrap_nofault", bus.misaligned_fault, 0);
        wait_hold("hwrap", 32'h0000_0000); retire(2'b01, 32'h0000_0100, 0);
        expect_fetch("to_100", 32'h0000_0100);
        wait_hold("h100", 32'h0000_0100); retire(2'b11, 0, 0);
        expect_fetch("trap_sel", TRAP_VECTOR);
        wait_hold("htrap", 32'h0000_0000); retire(2'b01, 32'h0000_0102, 0);
        check("imm_fault_addr", bus.fault_addr, 32'h0000_0102);
        check("imm_fault_pc", bus.imem_req_addr, 32'h0000_0000);
        bus.fault_ack = 1'b1; step(); bus.fault_ack = 1'b0;
        expect_fetch("ack_fetch", 32'h0000_0000);

        // reset while a request is outstanding, stale response afterwards
        bus.imem_resp_valid = 1'b0;
        step();
        check("inflight_wait", bus.imem_req_valid, 0);
        reset_n = 1'b0;
        #1;
        check("midrst_addr", bus.imem_req_addr, 32'h0040_0000);
        check("midrst_req", bus.imem_req_valid, 0);
        step();
        bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'hBAD0_BAD0;
        reset_n = 1'b1;
        repeat (3) begin
            step();
            check("stale_inst_valid", bus.inst_valid, 0);
            check("refetch_addr", bus.imem_req_addr, 32'h0040_0000);
            check("refetch_valid", bus.imem_req_valid, 1);
        end
        bus.imem_resp_data = 32'h0000_0013; bus.imem_req_ready = 1'b1;
        wait_hold("after_rst", 32'h0040_0000);
        check("after_rst_inst", bus.inst, 32'h0000_0013);

        step();
        run_cmp = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_fetch_sequencer.md
PC_FETCH_SEQUENCER -- requirements
Module: pc_fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0040_0000: first fetch address after reset.
REQ-002 SHALL have parameter TRAP_VECTOR, default 32'h0000_0000: target for next_pc_select=2'b11 and for misaligned-target recovery.
REQ-003 SHALL have port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port imem_req_valid, output, 1: fetch request valid.
REQ-006 SHALL have port imem_req_addr, output, 32: fetch address; equals pc.
REQ-007 SHALL have port imem_req_ready, input, 1: memory accepts request.
REQ-008 SHALL have port imem_resp_valid, input, 1: instruction word returned.
REQ-009 SHALL have port imem_resp_data, input, 32: returned instruction.
REQ-010 SHALL have port inst_valid, output, 1: instruction presented to the core.
REQ-011 SHALL have port inst, output, 32: held instruction.
REQ-012 SHALL have port inst_pc, output, 32: address of held instruction.
REQ-013 SHALL have port inst_ready, input, 1: core retires the held instruction this cycle.
REQ-014 SHALL have port next_pc_select, input, 2: 00 pc+4, 01 pc+imm, 10 {jalr_target[31:1],1'b0}, 11 TRAP_VECTOR.
REQ-015 SHALL have port immediate, input, 32: branch/jal offset.
REQ-016 SHALL have port jalr_target, input, 32: rs1+imm sum.
REQ-017 SHALL have port misaligned_fault, output, 1: computed target not 4-byte aligned.
REQ-018 SHALL have port fault_addr, output, 32: offending target address.
REQ-019 SHALL have port fault_ack, input, 1: trap handler acknowledges fault.

Function
REQ-020 SHALL implement states FETCH, WAIT, HOLD, FAULT.
REQ-021 FETCH: imem_req_valid=1; on imem_req_ready SHALL go to WAIT.
REQ-022 WAIT: imem_req_valid=0; on imem_resp_valid SHALL latch imem_resp_data into inst, pc into inst_pc, go to HOLD.
REQ-023 HOLD: inst_valid=1; inst, inst_pc SHALL remain stable until inst_ready.
REQ-024 HOLD with inst_ready: SHALL compute target from next_pc_select, sampled only in that cycle; arithmetic modulo 2^32, carries discarded.
REQ-025 target[1:0]==2'b00 SHALL load pc<=target and go to FETCH on the next cycle.
REQ-026 target[1:0]!=2'b00 SHALL leave pc unchanged, set fault_addr<=target, and go to FAULT.
REQ-027 FAULT: misaligned_fault=1, imem_req_valid=0, inst_valid=0; on fault_ack SHALL load pc<=TRAP_VECTOR and go to FETCH.
REQ-028 imem_resp_valid outside WAIT SHALL be ignored; inst_ready outside HOLD SHALL be ignored; fault_ack outside FAULT SHALL be ignored.
REQ-029 imem_req_addr SHALL NOT change while imem_req_valid=1 and imem_req_ready=0.
REQ-030 Minimum loop latency SHALL be 3 cycles per instruction: FETCH, WAIT, HOLD, with zero-wait memory and inst_ready high.
REQ-031 A request accepted in the same cycle as its response SHALL NOT be supported; the response is taken no earlier than the cycle after acceptance.
REQ-032 pc+4 from 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000 without fault.
REQ-033 next_pc_select=2'b10 SHALL clear bit 0 before the alignment check, so only bit 1 can fault.

Reset
REQ-034 reset_n low SHALL immediately force state FETCH and pc=RESET_PC.
REQ-035 reset_n low SHALL immediately force inst=0, inst_pc=0, fault_addr=0, inst_valid=0, misaligned_fault=0.
REQ-036 imem_req_valid SHALL be 0 while reset_n is low and SHALL assert on the first rising clock edge after reset_n is released.
REQ-037 Reset mid-transaction SHALL discard in-flight responses; a response arriving after release, before a new acceptance, SHALL be ignored.

Verification
REQ-038 Release reset with zero-wait memory returning 32'h0000_0013 and inst_ready=1 -> imem_req_addr 0x00400000, then 0x00400004 three cycles later; inst_pc=0x00400000.
REQ-039 HOLD at pc 0x00400010, sel=01, immediate=32'hFFFF_FFF0 -> next imem_req_addr 0x00400000.
REQ-040 sel=10, jalr_target=0x00400021 -> fetch 0x00400020, no fault; jalr_target=0x00400022 -> misaligned_fault=1, fault_addr=0x00400022; fault_ack -> fetch 0x00000000.
REQ-041 imem_req_ready held low 5 cycles -> imem_req_valid=1 and imem_req_addr stable for all 5 cycles; inst_ready held low 4 cycles in HOLD -> inst and inst_pc stable.
REQ-042 pc=0xFFFF_FFFC, sel=00 -> fetch 0x00000000; sel=11 from any pc -> fetch TRAP_VECTOR.
REQ-043 Assert reset_n low during WAIT, pulse imem_resp_valid after release before acceptance -> inst_valid stays 0; refetch from 0x00400000.
